// File: rtl/matrix_scan_encoder.sv
// rtl/matrix_scan_encoder.sv - 8x8 key matrix scanner emitting PS/2-style event words
// Optional macro KBD_DEBOUNCE_EN: a column change counts only after two agreeing scan passes.
module matrix_scan_encoder #(
    parameter int SCAN_DIV = 64,
    parameter int GAP      = 1024
) (
    input  logic        clk_sys,
    input  logic        reset,
    output logic [7:0]  row_sel,
    input  logic [7:0]  col_in,
    output logic [10:0] ps2_key,
    output logic        busy
);
    localparam int DW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam int GW = $clog2(GAP + 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
    localparam logic [GW-1:0] GAP_LOAD = GW'(GAP);

    typedef enum logic [1:0] {
        S_DRIVE   = 2'd0,
        S_SAMPLE  = 2'd1,
        S_ADVANCE = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_next_state;
    logic [2:0]    r_row;
    logic [DW-1:0] r_div;
    logic [GW-1:0] r_gap;
    logic [7:0]    r_st [8];
    logic [10:0]   r_key;
`ifdef KBD_DEBOUNCE_EN
    logic [7:0]    r_prev [8];
`endif

    logic [7:0]    w_diff;
    logic          w_hit;
    logic [2:0]    w_col;
    logic [63:0]   w_rom_row;
    logic [7:0]    w_code;
    logic          w_ext;
    logic          w_busy;
    logic          w_sampling;
    logic          w_emit;
    logic          w_leave_sample;

    // Scancodes packed column 7 in the top byte down to column 0 in the bottom byte.
    function automatic logic [63:0] f_rom_row(input logic [2:0] row);
        case (row)
            3'd0:    f_rom_row = 64'h00_29_5A_58_83_01_00_7E;
            3'd1:    f_rom_row = 64'h45_0A_72_54_5B_4D_44_43;
            3'd2:    f_rom_row = 64'h03_46_74_5D_52_4C_4B_42;
            3'd3:    f_rom_row = 64'h0C_79_4E_66_3E_4A_49_41;
            3'd4:    f_rom_row = 64'h04_16_1E_26_25_2E_36_3D;
            3'd5:    f_rom_row = 64'h06_15_1D_24_2D_2C_35_3C;
            3'd6:    f_rom_row = 64'h05_1C_1B_23_2B_34_33_3B;
            default: f_rom_row = 64'h0B_1A_22_21_2A_32_31_3A;
        endcase
    endfunction

    always_comb begin
`ifdef KBD_DEBOUNCE_EN
        w_diff = (col_in ^ r_st[r_row]) & ~(col_in ^ r_prev[r_row]);
`else
        w_diff = col_in ^ r_st[r_row];
`endif
        w_hit = |w_diff;
        w_col = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (w_diff[i]) w_col = 3'(i);
        end
        w_rom_row = f_rom_row(r_row);
        w_code    = w_rom_row[{w_col, 3'b000} +: 8];
        w_ext     = (w_code == 8'h72) || (w_code == 8'h74);
    end

    always_ff @(posedge clk_sys) begin
        if (reset) r_state <= S_DRIVE;
        else       r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_DRIVE:   if (r_div == DIV_LAST) w_next_state = S_SAMPLE;
            S_SAMPLE:  if (!w_hit || !w_busy) w_next_state = S_ADVANCE;
            S_ADVANCE: w_next_state = S_DRIVE;
            default:   w_next_state = S_DRIVE;
        endcase
    end

    always_comb begin
        row_sel        = ~(8'd1 << r_row);
        w_busy         = (r_gap != '0);
        w_sampling     = (r_state == S_SAMPLE);
        w_emit         = w_sampling && w_hit && !w_busy;
        w_leave_sample = w_sampling && (!w_hit || !w_busy);
    end

    assign busy    = w_busy;
    assign ps2_key = r_key;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_row <= 3'd0;
            r_div <= '0;
        end else begin
            if ((r_state == S_DRIVE) && (r_div != DIV_LAST)) r_div <= r_div + DW'(1);
            else                                             r_div <= '0;
            if (r_state == S_ADVANCE) r_row <= r_row + 3'd1;
        end
    end

    // Blank ROM slots still track key state so they never re-trigger, but stay silent.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_key <= '0;
            r_gap <= '0;
            for (int i = 0; i < 8; i++) r_st[i] <= 8'hFF;
        end else begin
            if (w_emit) r_st[r_row][w_col] <= col_in[w_col];
            if (w_emit && (w_code != 8'h00)) begin
                r_key <= {~r_key[10], ~col_in[w_col], w_ext, w_code};
                r_gap <= GAP_LOAD;
            end else if (w_busy) begin
                r_gap <= r_gap - GW'(1);
            end
        end
    end

`ifdef KBD_DEBOUNCE_EN
    // History advances once per pass, so busy re-sampling cannot fake agreement.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) r_prev[i] <= 8'hFF;
        end else if (w_leave_sample) begin
            r_prev[r_row] <= col_in;
        end
    end
`endif

endmodule

// File: tb/tb_matrix_scan_encoder.sv
// tb/tb_matrix_scan_encoder.sv - randomized self-checking bench for matrix_scan_encoder
module tb_matrix_scan_encoder;
    localparam int SCAN_DIV = 4;
    localparam int GAP      = 16;
    localparam int PASS     = 8 * (SCAN_DIV + 2);

    logic        clk_sys = 1'b0;
    logic        reset   = 1'b1;
    logic [7:0]  row_sel;
    logic [7:0]  col_in;
    logic [10:0] ps2_key;
    logic        busy;

    logic [7:0]  keys [8];
    int          n_checks = 0;
    int          n_fail   = 0;
    bit          chk_en   = 1'b0;

    logic [7:0] rom_tb [64] = '{
        8'h7E, 8'h00, 8'h01, 8'h83, 8'h58, 8'h5A, 8'h29, 8'h00,
        8'h43, 8'h44, 8'h4D, 8'h5B, 8'h54, 8'h72, 8'h0A, 8'h45,
        8'h42, 8'h4B, 8'h4C, 8'h52, 8'h5D, 8'h74, 8'h46, 8'h03,
        8'h41, 8'h49, 8'h4A, 8'h3E, 8'h66, 8'h4E, 8'h79, 8'h0C,
        8'h3D, 8'h36, 8'h2E, 8'h25, 8'h26, 8'h1E, 8'h16, 8'h04,
        8'h3C, 8'h35, 8'h2C, 8'h2D, 8'h24, 8'h1D, 8'h15, 8'h06,
        8'h3B, 8'h33, 8'h34, 8'h2B, 8'h23, 8'h1B, 8'h1C, 8'h05,
        8'h3A, 8'h31, 8'h32, 8'h2A, 8'h21, 8'h22, 8'h1A, 8'h0B
    };

    matrix_scan_encoder #(.SCAN_DIV(SCAN_DIV), .GAP(GAP)) dut (
        .clk_sys (clk_sys),
        .reset   (reset),
        .row_sel (row_sel),
        .col_in  (col_in),
        .ps2_key (ps2_key),
        .busy    (busy)
    );

    always #5 clk_sys = ~clk_sys;

    // Key matrix: a pressed key pulls its column low while its row is driven.
    always_comb begin
        col_in = 8'hFF;
        for (int i = 0; i < 8; i++) begin
            if (row_sel == ~(8'd1 << i)) col_in = ~keys[i];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: each row is driven SCAN_DIV cycles, sampled (repeatedly while an
    // event waits on the gap), then one advance cycle; busy covers GAP cycles after an event.
    int          m_phase, m_cnt, m_row, m_cyc, m_ev_cyc, m_c;
    bit          m_has_ev;
    logic [7:0]  m_st [8];
    logic [7:0]  m_prev [8];
    logic [7:0]  m_smp, m_diff, m_code;
    logic [10:0] m_key;

    function automatic bit m_busy_now();
        return m_has_ev && (m_cyc >= m_ev_cyc) && (m_cyc < m_ev_cyc + GAP);
    endfunction

    initial forever begin
        @(posedge clk_sys);
        if (reset) begin
            m_phase = 0; m_cnt = 0; m_row = 0; m_cyc = 0; m_has_ev = 1'b0; m_key = '0;
            for (int i = 0; i < 8; i++) begin
                m_st[i] = 8'hFF;
                m_prev[i] = 8'hFF;
            end
        end else begin
            if (m_phase == 0) begin
                m_cnt++;
                if (m_cnt == SCAN_DIV) begin
                    m_cnt = 0;
                    m_phase = 1;
                end
            end else if (m_phase == 1) begin
                m_smp  = ~keys[m_row];
                m_diff = m_smp ^ m_st[m_row];
`ifdef KBD_DEBOUNCE_EN
                m_diff = m_diff & ~(m_smp ^ m_prev[m_row]);
`endif
                if (!((m_diff != 8'h00) && m_busy_now())) begin
                    if (m_diff != 8'h00) begin
                        m_c = 0;
                        for (int i = 7; i >= 0; i--) if (m_diff[i]) m_c = i;
                        m_st[m_row][m_c] = m_smp[m_c];
                        m_code = rom_tb[m_row * 8 + m_c];
                        if (m_code != 8'h00) begin
                            m_key = {~m_key[10], ~m_smp[m_c],
                                     (m_code == 8'h72) || (m_code == 8'h74), m_code};
                            m_has_ev = 1'b1;
                            m_ev_cyc = m_cyc + 1;
                        end
                    end
                    m_prev[m_row] = m_smp;
                    m_phase = 2;
                end
            end else begin
                m_row = (m_row + 1) % 8;
                m_phase = 0;
            end
            m_cyc++;
        end
    end

    logic [7:0] exp_rs;
    initial forever begin
        @(negedge clk_sys);
        if (chk_en) begin
            exp_rs = ~(8'd1 << m_row);
            check("row_sel", {24'd0, row_sel}, {24'd0, exp_rs});
            check("busy", {31'd0, busy}, {31'd0, m_busy_now()});
            check("ps2_key", {21'd0, ps2_key}, {21'd0, m_key});
        end
    end

    task automatic wait_key(input string name, input int limit, output int waited);
        logic [10:0] old;
        bit          seen;
        old = ps2_key;
        seen = 1'b0;
        waited = 0;
        while (!seen && waited < limit) begin
            @(negedge clk_sys);
            waited++;
            if (ps2_key !== old) seen = 1'b1;
        end
        if (!seen) check({name, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic wait_row(input int r, input int limit);
        logic [7:0] want;
        int         n;
        want = ~(8'd1 << r);
        n = 0;
        while (row_sel !== want && n < limit) begin
            @(negedge clk_sys);
            n++;
        end
        if (row_sel !== want) check("row_wait_timeout", 32'd0, 32'd1);
    endtask

    task automatic quiet_window(input int cycles, output int changes, output int busy_hi);
        logic [10:0] last;
        last = ps2_key;
        changes = 0;
        busy_hi = 0;
        repeat (cycles) begin
            @(negedge clk_sys);
            if (ps2_key !== last) changes++;
            if (busy !== 1'b0) busy_hi++;
            last = ps2_key;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    int n, chg, bh, rr, cc;
    initial begin
        for (int i = 0; i < 8; i++) keys[i] = 8'h00;
        keys[5][4] = 1'b1;
        repeat (3) @(posedge clk_sys);
        @(negedge clk_sys);
        chk_en = 1'b1;
        check("reset_key", {21'd0, ps2_key}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        reset = 1'b0;
        @(negedge clk_sys);
        check("row_after_reset", {24'd0, row_sel}, 32'hFE);

        wait_key("e_press", 4 * PASS, n);
        check("e_press", {21'd0, ps2_key}, 32'h624);
        keys[5][4] = 1'b0;
        wait_key("e_release", 4 * PASS, n);
        check("e_release", {21'd0, ps2_key}, 32'h024);

        keys[1][5] = 1'b1;
        wait_key("ext72_press", 4 * PASS, n);
        check("ext72_press", {22'd0, ps2_key[9:0]}, 32'h372);
        keys[1][5] = 1'b0;
        wait_key("ext72_release", 4 * PASS, n);
        check("ext72_release", {22'd0, ps2_key[9:0]}, 32'h172);

        keys[7][1] = 1'b1;
        keys[7][6] = 1'b1;
        wait_key("dual_first", 4 * PASS, n);
        check("dual_first", {22'd0, ps2_key[9:0]}, 32'h231);
        wait_key("dual_second", 4 * PASS, n);
        check("dual_second", {22'd0, ps2_key[9:0]}, 32'h21A);
        check("dual_gap_ok", {31'd0, (n >= GAP)}, 32'd1);
        keys[7][1] = 1'b0;
        keys[7][6] = 1'b0;
        wait_key("dual_rel1", 4 * PASS, n);
        check("dual_rel1", {22'd0, ps2_key[9:0]}, 32'h031);
        wait_key("dual_rel2", 4 * PASS, n);
        check("dual_rel2", {22'd0, ps2_key[9:0]}, 32'h01A);

        repeat (2 * GAP) @(negedge clk_sys);
        keys[0][7] = 1'b1;
        quiet_window(3 * PASS, chg, bh);
        check("blank_press_changes", chg, 32'd0);
        check("blank_press_busy", bh, 32'd0);
        keys[0][7] = 1'b0;
        quiet_window(3 * PASS, chg, bh);
        check("blank_release_changes", chg, 32'd0);

        keys[2][5] = 1'b1;
        wait_key("ext74_press", 4 * PASS, n);
        check("ext74_press", {22'd0, ps2_key[9:0]}, 32'h374);
        repeat (5) @(negedge clk_sys);
        reset = 1'b1;
        @(negedge clk_sys);
        check("midgap_reset_key", {21'd0, ps2_key}, 32'd0);
        check("midgap_reset_busy", {31'd0, busy}, 32'd0);
        repeat (2) @(negedge clk_sys);
        reset = 1'b0;
        wait_key("rereport", 4 * PASS, n);
        check("rereport", {21'd0, ps2_key}, 32'h774);
        keys[2][5] = 1'b0;
        wait_key("ext74_release", 4 * PASS, n);
        check("ext74_release", {21'd0, ps2_key}, 32'h174);

        for (int it = 0; it < 60; it++) begin
            rr = $urandom_range(0, 7);
            cc = $urandom_range(0, 7);
            keys[rr][cc] = ~keys[rr][cc];
            if ($urandom_range(0, 3) == 0) keys[$urandom_range(0, 7)][$urandom_range(0, 7)] = 1'b1;
            repeat ($urandom_range(0, 120)) @(negedge clk_sys);
        end
        for (int i = 0; i < 8; i++) keys[i] = 8'h00;
        repeat (40 * PASS) @(negedge clk_sys);

`ifdef KBD_DEBOUNCE_EN
        wait_row(2, 4 * PASS);
        keys[3][3] = 1'b1;
        wait_row(4, 4 * PASS);
        keys[3][3] = 1'b0;
        quiet_window(3 * PASS, chg, bh);
        check("glitch_no_event", chg, 32'd0);
        keys[3][3] = 1'b1;
        wait_key("debounced_press", 6 * PASS, n);
        check("debounced_press", {22'd0, ps2_key[9:0]}, 32'h23E);
        keys[3][3] = 1'b0;
        wait_key("debounced_release", 6 * PASS, n);
        check("debounced_release", {22'd0, ps2_key[9:0]}, 32'h03E);
`endif

        repeat (4) @(negedge clk_sys);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
